// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time and period of an asynchronous PWM input
// Results are a registered pair with a one-cycle valid strobe; timeout flags a stuck line.
module pwm_capture #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] high_cnt,
   output logic [WIDTH-1:0] period_cnt,
   output logic             valid,
   output logic             timeout,
   output logic             stuck_level
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_len_q, hi_len_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic             stuck_q, stuck_d;
   logic             rise, fall, saturated;

   assign rise      = s2_q & ~s3_q;
   assign fall      = ~s2_q & s3_q;
   assign saturated = (cnt_q == CNT_MAX);

   // ena gates every register, the synchronizer included, so a paused block resumes untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         cnt_q     <= '0;
         hi_len_q  <= '0;
         high_q    <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         stuck_q   <= 1'b0;
      end else if (ena) begin
         state_q   <= state_d;
         s1_q      <= pwm_in;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         cnt_q     <= cnt_d;
         hi_len_q  <= hi_len_d;
         high_q    <= high_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         stuck_q   <= stuck_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_len_d  = hi_len_q;
      high_d    = high_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      stuck_d   = stuck_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               cnt_d   = CNT_ONE;
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (fall) begin
               hi_len_d = cnt_q;
               cnt_d    = cnt_q + CNT_ONE;
               state_d  = LOW;
            end else if (saturated) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               stuck_d   = s2_q;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         LOW: begin
            if (rise) begin
               high_d    = hi_len_q;
               period_d  = cnt_q;
               valid_d   = 1'b1;
               timeout_d = 1'b0;
               cnt_d     = CNT_ONE;
               state_d   = HIGH;
            end else if (saturated) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               stuck_d   = s2_q;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign high_cnt    = high_q;
   assign period_cnt  = period_q;
   assign valid       = valid_q;
   assign timeout     = timeout_q;
   assign stuck_level = stuck_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the team's PWM generator: samples an asynchronous PWM waveform and measures its high time and period in clock cycles. Results go out as a registered pair with a one-cycle valid strobe. A timeout flag reports a stuck-high or stuck-low line. It sits behind a dedicated input pin inside a tt_um_* top and drives uo_out/uio_out for loopback and characterisation of the generator.

## Interface
- WIDTH, 8: width of the cycle counters and the result registers; maximum measurable period is 2^WIDTH-1 cycles.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- ena  input  1  enable; when low, all state holds, including the synchronizer.
- pwm_in  input  1  asynchronous PWM waveform under measurement.
- high_cnt  output  WIDTH  high time of the last complete PWM cycle, in clk cycles.
- period_cnt  output  WIDTH  period of the last complete PWM cycle (rising to rising), in clk cycles.
- valid  output  1  single-cycle strobe; high_cnt/period_cnt updated this cycle.
- timeout  output  1  line stuck or period too long; level, cleared by the next valid.
- stuck_level  output  1  synchronized pwm_in level captured when timeout was set.

## Operation
- Synchronizer: two flops, s1 then s2. A third flop s3 holds the previous s2. rise = s2 & ~s3; fall = ~s2 & s3.
- Cycle counter cnt, WIDTH bits. Holding register hi_len, WIDTH bits.
- FSM states: IDLE, HIGH, LOW.
- IDLE, on rise: cnt=1, go to HIGH. No output update.
- HIGH, every cycle: cnt+=1.
- HIGH, on fall: hi_len=cnt, then cnt+=1, go to LOW.
- LOW, every cycle: cnt+=1.
- LOW, on rise: high_cnt=hi_len, period_cnt=cnt, valid=1, timeout=0. Then cnt=1, go to HIGH. Measurement is continuous; no IDLE between cycles.
- Counts include the edge cycle, so high_cnt + low time = period_cnt. With a steady input of H high and L low cycles: high_cnt=H, period_cnt=H+L.
- Saturation: in HIGH or LOW, if cnt == 2^WIDTH-1 and no edge arrives this cycle, then:
  - go to IDLE;
  - timeout=1;
  - stuck_level=s2;
  - high_cnt/period_cnt keep their last values.
- In IDLE, cnt holds and timeout holds until the next full measurement.
- An edge in the same cycle as saturation wins; it is processed normally.
- Minimum legal input: 1 cycle high and 1 cycle low at the pin, sampled cleanly. This gives high_cnt=1, period_cnt=2.
- ena=0: every register holds. Edges during that time are lost. Resume in the same state; the first measurement after resume may be invalid and is not flagged.
- The first rising edge after reset or a timeout only arms the block. The first valid follows one full period later.

## Timing
- Reset values: high_cnt=0, period_cnt=0, valid=0, timeout=0, stuck_level=0. Internally: state=IDLE, cnt=0, hi_len=0, s1=s2=s3=0.
- Reset asserted mid-measurement aborts immediately; the partial period is discarded.
- Pin to edge detect: pwm_in is first sampled high at clk edge k. s2=1 after edge k+1. rise is evaluated in cycle k+1..k+2, and state/outputs update at edge k+2.
- valid is high for exactly one cycle, in the same cycle that high_cnt/period_cnt show new values. Results stay stable until the next valid.
- Steady PWM produces valid strobes spaced exactly period_cnt cycles apart.
- timeout asserts one cycle after cnt reaches 2^WIDTH-1.

## Test plan
- Reset: pwm_in=0, rst_n low then released → all outputs 0, state IDLE, no valid for 10 cycles.
- Steady PWM, 3 cycles high / 7 low, WIDTH=8 → first valid after second rising edge with high_cnt=3, period_cnt=10; later valid strobes exactly 10 cycles apart; timeout=0.
- Minimum pulse, 1 high / 1 low repeating → high_cnt=1, period_cnt=2, valid every 2 cycles.
- Stuck line: after steady PWM, hold pwm_in=1 → timeout=1, stuck_level=1 once cnt reaches 255; old results retained. Restore a 5/5 PWM → after re-arm, valid with high_cnt=5, period_cnt=10, timeout=0.
- ena gating: drop ena for 20 cycles mid-HIGH with pwm_in steady → all outputs frozen, no valid. Raise ena → operation continues from the same state.
- Async reset mid-LOW: assert rst_n between clk edges → outputs 0 immediately, no valid; a fresh 3/7 PWM afterward gives correct results after one arming period.
